// File: rtl/lc2k_control.sv
// -----------------------------------------------------------------------------
// lc2k_control
// Multi-cycle sequencing controller for the LC2K CPU. Owns the PC and the
// instruction register, fetches through a single-port memory handshake,
// decodes the LC2K instruction format and steers the ALU, memory and register
// file for every instruction.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   memRdata, memReady  : memory read data / request-complete strobe
//   memReq, memWe       : memory request and write qualifier (sw)
//   memAddr             : pc in FETCH, aluResult in MEM
//   aluResult           : ALU result (load/store address, add/nor result)
//   CONTROL_BEQ         : ALU equal flag, sampled in EXEC of beq
//   CONTROL_OPERATION   : ALU op, 00 ADD / 01 NOR / 10 EQUAL
//   aluSrcB, offsetExt  : operand-B select and sign-extended IR[15:0]
//   regReadA, regReadB  : register-file read addresses IR[21:19] / IR[18:16]
//   regValA             : register-file port A data (jalr target)
//   regWe, regWaddr     : register-file write enable / address
//   regWsel             : write-data mux select 0 alu / 1 load data / 2 pc
//   loadData            : lw data captured on the MEM completion edge
//   pc, halted          : architectural PC, halt flag
//   instrCount          : retired instructions, including halt
// -----------------------------------------------------------------------------
module lc2k_control #(
   parameter int PC_W = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     memRdata,
   input  logic            memReady,
   output logic            memReq,
   output logic            memWe,
   output logic [PC_W-1:0] memAddr,
   input  logic [31:0]     aluResult,
   input  logic            CONTROL_BEQ,
   output logic [1:0]      CONTROL_OPERATION,
   output logic            aluSrcB,
   output logic [31:0]     offsetExt,
   output logic [2:0]      regReadA,
   output logic [2:0]      regReadB,
   input  logic [31:0]     regValA,
   output logic            regWe,
   output logic [2:0]      regWaddr,
   output logic [1:0]      regWsel,
   output logic [31:0]     loadData,
   output logic [PC_W-1:0] pc,
   output logic            halted,
   output logic [31:0]     instrCount
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALTED = 3'd5
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_NOR  = 3'd1;
   localparam logic [2:0] OP_LW   = 3'd2;
   localparam logic [2:0] OP_SW   = 3'd3;
   localparam logic [2:0] OP_BEQ  = 3'd4;
   localparam logic [2:0] OP_JALR = 3'd5;
   localparam logic [2:0] OP_HALT = 3'd6;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_NOR = 2'b01;
   localparam logic [1:0] ALU_EQ  = 2'b10;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [31:0]       cnt_q, cnt_d;
   logic              halted_q, halted_d;
   logic [31:0]       mdr_q;
   logic              retire;

   logic [2:0]        opcode;
   logic [2:0]        dest_reg;

   assign opcode    = ir_q[24:22];
   assign dest_reg  = ir_q[2:0];
   assign regReadA  = ir_q[21:19];
   assign regReadB  = ir_q[18:16];
   assign offsetExt = {{16{ir_q[15]}}, ir_q[15:0]};

   assign pc         = pc_q;
   assign halted     = halted_q;
   assign instrCount = cnt_q;
   assign loadData   = mdr_q;

   // Only the low PC_W bits of the address-carrying buses are consumed here.
   logic unused_bits;
   assign unused_bits = ^{ir_q[31:25], aluResult, regValA};

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_FETCH;
         pc_q     <= '0;
         ir_q     <= '0;
         cnt_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_d;
      end
   end

   // Load data register: plain datapath capture, no reset needed.
   always_ff @(posedge clk) begin
      if (state_q == S_MEM && memReady && opcode == OP_LW) begin
         mdr_q <= memRdata;
      end
   end

   // ---------------------------------------------------------- next state
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      cnt_d    = cnt_q;
      halted_d = halted_q;
      retire   = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            if (memReady) begin
               ir_d    = memRdata;
               pc_d    = pc_q + PC_W'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            unique case (opcode)
               OP_ADD, OP_NOR: state_d = S_WB;
               OP_LW, OP_SW:   state_d = S_MEM;
               OP_BEQ: begin
                  // pc already points past the branch, so the offset is
                  // applied relative to pc+1.
                  if (CONTROL_BEQ) pc_d = pc_q + offsetExt[PC_W-1:0];
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
               OP_JALR: begin
                  // Target is the register value read before the link write
                  // lands, so regA==regB still jumps to the old value.
                  pc_d    = regValA[PC_W-1:0];
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
               OP_HALT: begin
                  halted_d = 1'b1;
                  state_d  = S_HALTED;
                  retire   = 1'b1;
               end
               default: begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            if (memReady) begin
               if (opcode == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_FETCH;
      endcase

      if (retire) cnt_d = cnt_q + 32'd1;
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      memReq            = 1'b0;
      memWe             = 1'b0;
      memAddr           = pc_q;
      CONTROL_OPERATION = ALU_ADD;
      aluSrcB           = 1'b0;
      regWe             = 1'b0;
      regWaddr          = '0;
      regWsel           = 2'd0;

      unique case (state_q)
         S_FETCH: memReq = 1'b1;
         S_EXEC: begin
            unique case (opcode)
               OP_NOR:       CONTROL_OPERATION = ALU_NOR;
               OP_LW, OP_SW: aluSrcB = 1'b1;
               OP_BEQ:       CONTROL_OPERATION = ALU_EQ;
               OP_JALR: begin
                  regWe    = 1'b1;
                  regWaddr = regReadB;
                  regWsel  = 2'd2;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            memReq  = 1'b1;
            memWe   = (opcode == OP_SW);
            memAddr = aluResult[PC_W-1:0];
            aluSrcB = 1'b1;
         end
         S_WB: begin
            regWe = 1'b1;
            if (opcode == OP_LW) begin
               regWaddr = regReadB;
               regWsel  = 2'd1;
            end else begin
               regWaddr = dest_reg;
               regWsel  = 2'd0;
               // Hold NOR so the ALU result stays valid through write-back.
               if (opcode == OP_NOR) CONTROL_OPERATION = ALU_NOR;
            end
         end
         default: ;
      endcase
   end

endmodule
